joypad_port: RTL and testbench

- Parametrised NES-style joypad interface for the 2A03 system; it supersedes the raw single-wire controller passthrough at $4016.
- A free-running poll engine drives the shared latch and serial clock lines, shifts in BITS_PER_PAD bits from each of NUM_PADS pads, and commits an atomic snapshot.
- The CPU-facing side emulates the 4016/4017 strobe-and-shift read protocol from that snapshot.
- Sits in the peripherals address decode, clocked by the CPU clock.

---
 rtl/joypad_port_if.sv | 19 +
 rtl/joypad_port.sv | 220 ++++++++++++++++++++++
 tb/tb_joypad_port.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/joypad_port_if.sv
// CPU-side bus bundle for joypad_port.
//   addr     16  CPU address
//   rw        1  1=read, 0=write
//   access    1  one-cycle bus-cycle qualifier
//   data_in   8  CPU write data
//   data_out  8  registered read data (device -> CPU)
//   hit       1  registered decode hit (device -> CPU)
// master = CPU / bus fabric, slave = joypad_port.
interface joypad_port_if;
  logic [15:0] addr;
  logic        rw;
  logic        access;
  logic [7:0]  data_in;
  logic [7:0]  data_out;
  logic        hit;

  modport master (output addr, rw, access, data_in, input data_out, hit);
  modport slave  (input addr, rw, access, data_in, output data_out, hit);
endinterface

// File: rtl/joypad_port.sv
// joypad_port: NES-style joypad poller plus 4016/4017 strobe-and-shift
// read emulation. A free-running engine drives pad_latch/pad_clk, shifts
// BITS_PER_PAD bits from each pad and commits all pads' snapshots at once;
// CPU reads are served from those snapshots and never stall.
// Ports:
//   clock, reset      CPU clock, synchronous active-high reset
//   bus               joypad_port_if.slave (addr/rw/access/data_in in,
//                     data_out/hit registered out)
//   pad_latch         shared latch line, active-high
//   pad_clk           shared serial clock, idles high
//   pad_data          per-pad serial data, active-low
//   busy              poll in progress
// Optional: define JOYPAD_PARALLEL_READ_EN for byte-wide snapshot reads at
// BASE_ADDR+8+i and a poll status/counter byte at BASE_ADDR+8+NUM_PADS.

// Per-pad capture / snapshot / CPU shift register.
module joypad_lane #(
  parameter int BITS = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       sample,      // capture one serial bit this cycle
  input  logic       sample_bit,  // already inverted: 1 = pressed
  input  logic       commit,      // copy capture into snapshot
  input  logic       strobe,
  input  logic       rd,          // CPU read of this pad
  output logic       rd_bit
`ifdef JOYPAD_PARALLEL_READ_EN
  ,
  output logic [7:0] snap_byte
`endif
);
  logic [BITS-1:0] cap, snap, shift;

  always_ff @(posedge clock) begin
    if (reset) begin
      cap   <= '0;
      snap  <= '0;
      shift <= '0;
    end else begin
      // bits arrive bit0 first; a full poll overwrites every position
      if (sample) cap <= {sample_bit, cap[BITS-1:1]};
      if (commit) snap <= cap;
      if (strobe)  shift <= snap;
      else if (rd) shift <= {1'b1, shift[BITS-1:1]};
    end
  end

  // while strobed the pad keeps reporting its first button
  assign rd_bit = strobe ? snap[0] : shift[0];
`ifdef JOYPAD_PARALLEL_READ_EN
  assign snap_byte = 8'(snap);
`endif
endmodule

module joypad_port #(
  parameter int          NUM_PADS     = 2,
  parameter int          BITS_PER_PAD = 8,
  parameter int          CLK_DIV      = 6,
  parameter int          POLL_PERIOD  = 4096,
  parameter logic [15:0] BASE_ADDR    = 16'h4016
) (
  input  logic                clock,
  input  logic                reset,
  joypad_port_if.slave        bus,
  output logic                pad_latch,
  output logic                pad_clk,
  input  logic [NUM_PADS-1:0] pad_data,
  output logic                busy
);
  localparam int TW = $clog2(POLL_PERIOD);
  localparam int DW = $clog2(CLK_DIV) + 1;
  localparam int BW = $clog2(BITS_PER_PAD) + 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LATCH  = 3'd1;
  localparam logic [2:0] S_CLK_LO = 3'd2;
  localparam logic [2:0] S_CLK_HI = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]    state;
  logic [TW-1:0] timer;
  logic [DW-1:0] div_cnt;
  logic [BW-1:0] bit_cnt;
  logic          div_last, timer_last, sample, commit;
  logic          strobe_reg, strobe_wr;
  logic [15:0]   off;
  logic [NUM_PADS-1:0] pad_rd, rd_bit;
  logic [7:0]    data_nxt;
  logic          hit_nxt;
  logic          unused_data;

  assign unused_data = ^bus.data_in[7:1];
  assign div_last    = div_cnt == DW'(CLK_DIV - 1);
  assign timer_last  = timer == TW'(POLL_PERIOD - 1);
  assign sample      = div_last && (state == S_LATCH || state == S_CLK_HI);
  assign commit      = state == S_DONE;

  // poll engine; the timer free-runs so poll starts are exactly periodic
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_IDLE;
      timer     <= '0;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      pad_latch <= 1'b0;
      pad_clk   <= 1'b1;
      busy      <= 1'b0;
    end else begin
      timer <= timer_last ? '0 : timer + 1'b1;
      case (state)
        S_IDLE: if (timer_last) begin
          state     <= S_LATCH;
          pad_latch <= 1'b1;
          busy      <= 1'b1;
          div_cnt   <= '0;
          bit_cnt   <= '0;
        end
        S_LATCH: if (div_last) begin
          state     <= S_CLK_LO;
          pad_latch <= 1'b0;
          pad_clk   <= 1'b0;
          div_cnt   <= '0;
          bit_cnt   <= BW'(1);   // bit0 taken under latch
        end else div_cnt <= div_cnt + 1'b1;
        S_CLK_LO: if (div_last) begin
          state   <= S_CLK_HI;
          pad_clk <= 1'b1;
          div_cnt <= '0;
        end else div_cnt <= div_cnt + 1'b1;
        S_CLK_HI: if (div_last) begin
          div_cnt <= '0;
          if (bit_cnt == BW'(BITS_PER_PAD - 1)) state <= S_DONE;
          else begin
            state   <= S_CLK_LO;
            pad_clk <= 1'b0;
            bit_cnt <= bit_cnt + 1'b1;
          end
        end else div_cnt <= div_cnt + 1'b1;
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // CPU decode
  assign off       = bus.addr - BASE_ADDR;
  assign strobe_wr = bus.access && !bus.rw && off == 16'd0;

  always_ff @(posedge clock) begin
    if (reset) strobe_reg <= 1'b0;
    else if (strobe_wr) strobe_reg <= bus.data_in[0];
  end

`ifdef JOYPAD_PARALLEL_READ_EN
  logic [NUM_PADS-1:0][7:0] snap_byte;
  logic [3:0] poll_cnt;

  always_ff @(posedge clock) begin
    if (reset) poll_cnt <= '0;
    else if (commit) poll_cnt <= poll_cnt + 1'b1;
  end
`endif

  for (genvar g = 0; g < NUM_PADS; g++) begin : g_lane
    assign pad_rd[g] = bus.access && bus.rw && off == 16'(g);
    joypad_lane #(.BITS(BITS_PER_PAD)) u_lane (
      .clock      (clock),
      .reset      (reset),
      .sample     (sample),
      .sample_bit (~pad_data[g]),
      .commit     (commit),
      .strobe     (strobe_reg),
      .rd         (pad_rd[g]),
      .rd_bit     (rd_bit[g])
`ifdef JOYPAD_PARALLEL_READ_EN
      ,
      .snap_byte  (snap_byte[g])
`endif
    );
  end

  always_comb begin
    data_nxt = '0;
    hit_nxt  = strobe_wr;
    for (int i = 0; i < NUM_PADS; i++) begin
      if (pad_rd[i]) begin
        hit_nxt  = 1'b1;
        data_nxt = {7'b0, rd_bit[i]};
      end
    end
`ifdef JOYPAD_PARALLEL_READ_EN
    if (bus.access && bus.rw) begin
      for (int i = 0; i < NUM_PADS; i++) begin
        if (off == 16'(8 + i)) begin
          hit_nxt  = 1'b1;
          data_nxt = snap_byte[i];
        end
      end
      if (off == 16'(8 + NUM_PADS)) begin
        hit_nxt  = 1'b1;
        data_nxt = {busy, 3'b0, poll_cnt};
      end
    end
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      bus.data_out <= '0;
      bus.hit      <= 1'b0;
    end else begin
      bus.data_out <= data_nxt;
      bus.hit      <= hit_nxt;
    end
  end
endmodule

// File: tb/tb_joypad_port.sv
module tb_joypad_port;
  localparam int NP = 2;
  localparam int B  = 8;
  localparam int CD = 6;
  localparam int PP = 4096;
  localparam int PLEN = CD * (2 * B - 1) + 1;  // 91

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pad_latch, pad_clk, busy;
  logic [NP-1:0] pad_data;
  logic [7:0] btn [NP];   // 1 = pressed
  int pidx = 0;

  int checks = 0, errors = 0;

  joypad_port_if bus();

  joypad_port u_dut (
    .clock     (clk),
    .reset     (rst),
    .bus       (bus),
    .pad_latch (pad_latch),
    .pad_clk   (pad_clk),
    .pad_data  (pad_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // 4021-style pad: latch reloads, each pad_clk rise advances one button
  always @(posedge pad_latch) pidx = 0;
  always @(posedge pad_clk) if (!pad_latch) pidx = pidx + 1;
  always_comb begin
    for (int i = 0; i < NP; i++)
      pad_data[i] = (pidx < B) ? ~btn[i][pidx] : 1'b1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int cyc = 0;               // clock edges since reset release
  logic [7:0] msnap [NP];
  logic [7:0] mshift [NP];
  bit   mstrobe;
  logic [7:0] exp_data;
  bit   exp_hit;
  int   mpolls;
  bit   started = 0;

  function automatic bit f_busy(int n);
    return n >= PP && (n % PP) < PLEN;
  endfunction
  function automatic bit f_latch(int n);
    return n >= PP && (n % PP) < CD;
  endfunction
  function automatic bit f_clk(int n);
    int p;
    p = n % PP;
    if (n >= PP && p >= CD && p < PLEN - 1 && ((p - CD) % (2 * CD)) < CD) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    int o;
    logic [7:0] nd;
    bit nh;
    if (rst) begin
      started = 1;
      cyc = 0; mstrobe = 0; exp_data = 0; exp_hit = 0; mpolls = 0;
      for (int i = 0; i < NP; i++) begin msnap[i] = 0; mshift[i] = 0; end
    end else begin
      o = int'(bus.addr) - 16'h4016;
      nd = 0; nh = 0;
      if (bus.access && !bus.rw && o == 0) nh = 1;
      if (bus.access && bus.rw) begin
        if (o >= 0 && o < NP) begin
          nh = 1;
          nd = {7'b0, mstrobe ? msnap[o][0] : mshift[o][0]};
          if (!mstrobe) mshift[o] = {1'b1, mshift[o][7:1]};
        end
`ifdef JOYPAD_PARALLEL_READ_EN
        else if (o >= 8 && o < 8 + NP) begin nh = 1; nd = msnap[o-8]; end
        else if (o == 8 + NP) begin
          nh = 1;
          nd = {f_busy(cyc), 3'b0, 4'(mpolls)};
        end
`endif
      end
      if (mstrobe) for (int i = 0; i < NP; i++) mshift[i] = msnap[i];
      if (bus.access && !bus.rw && o == 0) mstrobe = bus.data_in[0];
      cyc++;
      if (cyc > PP && cyc % PP == PLEN) begin
        for (int i = 0; i < NP; i++) msnap[i] = btn[i];
        mpolls++;
      end
      exp_data = nd; exp_hit = nh;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("m_data", bus.data_out, exp_data);
      chk("m_hit", bus.hit, exp_hit);
      chk("m_busy", busy, f_busy(cyc));
      chk("m_latch", pad_latch, f_latch(cyc));
      chk("m_clk", pad_clk, f_clk(cyc));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.access = 1; bus.rw = 0; bus.addr = a; bus.data_in = d;
    @(negedge clk);
    bus.access = 0;
  endtask

  task automatic rd(input string name, input logic [15:0] a, input logic [7:0] exp, input bit eh);
    @(negedge clk);
    bus.access = 1; bus.rw = 1; bus.addr = a;
    @(negedge clk);
    bus.access = 0;
    chk({name, "_d"}, bus.data_out, exp);
    chk({name, "_h"}, bus.hit, eh);
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!busy && n < 5000) begin @(negedge clk); n++; end
    while (busy && n < 5000) begin @(negedge clk); n++; end
    if (n >= 5000) chk({name, "_timeout"}, 1, 0);
  endtask

  initial begin
    int n, bc;
    logic [7:0] seq10 [10];
    bus.access = 0; bus.rw = 1; bus.addr = 16'h0; bus.data_in = 8'h0;
    btn[0] = 8'h09; btn[1] = 8'h80;
    repeat (3) @(negedge clk);
    chk("rst_data", bus.data_out, 0);
    chk("rst_hit", bus.hit, 0);
    chk("rst_latch", pad_latch, 0);
    chk("rst_clk", pad_clk, 1);
    chk("rst_busy", busy, 0);
    rst = 0;

    // first poll: busy must stay high for exactly 91 cycles
    n = 0; bc = 0;
    while (!busy && n < 5000) begin @(negedge clk); n++; end
    while (busy && n < 5000) begin @(negedge clk); n++; bc++; end
    chk("first_poll_timeout", n >= 5000, 0);
    chk("busy_len", bc, 91);

    // strobe then shift out pad 0 (A, Start pressed)
    seq10 = '{1, 0, 0, 1, 0, 0, 0, 0, 1, 1};
    wr(16'h4016, 8'h01); wr(16'h4016, 8'h00);
    for (int i = 0; i < 10; i++) rd($sformatf("p0_r%0d", i), 16'h4016, seq10[i], 1);

    // pad 1 shifts independently of pad 0
    wr(16'h4016, 8'hFF); wr(16'h4016, 8'hFE);
    rd("p0_a", 16'h4016, 1, 1); rd("p0_b", 16'h4016, 0, 1); rd("p0_c", 16'h4016, 0, 1);
    for (int i = 0; i < 8; i++) rd($sformatf("p1_r%0d", i), 16'h4017, (i == 7) ? 8'h1 : 8'h0, 1);
    rd("p0_d", 16'h4016, 1, 1); rd("p0_e", 16'h4016, 0, 1);

    // out-of-range and unimplemented addresses
    rd("pad2", 16'h4018, 0, 0);
    wr(16'h4017, 8'h01);
    rd("p0_after_4017wr", 16'h4016, 0, 1);
`ifdef JOYPAD_PARALLEL_READ_EN
    rd("par0", 16'h401E, 8'h09, 1);
    rd("par1", 16'h401F, 8'h80, 1);
`else
    rd("par0_off", 16'h401E, 0, 0);
`endif

    // strobe held: no shift; new snapshot seen after next poll
    wr(16'h4016, 8'h01);
    for (int i = 0; i < 3; i++) rd($sformatf("strb_r%0d", i), 16'h4016, 1, 1);
    btn[0] = 8'h08;
    wait_done("strb_poll");
    rd("strb_new", 16'h4016, 0, 1);
    wr(16'h4016, 8'h00);

    // reset during CLK_LO of bit 3
    n = 0;
    while (!(cyc >= PP && cyc % PP == 32) && n < 6000) begin @(negedge clk); n++; end
    chk("clklo_wait_timeout", n >= 6000, 0);
    chk("pre_rst_clk", pad_clk, 0);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("mid_rst_latch", pad_latch, 0);
    chk("mid_rst_clk", pad_clk, 1);
    chk("mid_rst_busy", busy, 0);
    wr(16'h4016, 8'h01);
    rd("mid_rst_snap", 16'h4016, 0, 1);
    wr(16'h4016, 8'h00);
    n = 0;
    while (!busy && n < 5000) begin @(negedge clk); n++; end
    chk("restart_timeout", n >= 5000, 0);
    chk("restart_cyc", cyc, 4096);

`ifdef JOYPAD_PARALLEL_READ_EN
    btn[0] = 8'h09;
    n = 0;
    while (cyc < 3 * PP + PLEN + 2 && n < 20000) begin @(negedge clk); n++; end
    chk("cnt_wait_timeout", n >= 20000, 0);
    rd("poll_cnt", 16'h4020, 8'h03, 1);
    rd("par0_again", 16'h401E, 8'h09, 1);
`endif

    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
